// File: rtl/moving_average_filter_pkg.sv
// Shared window-depth default and FSM state encoding for the moving-average filter.
package moving_average_filter_pkg;

  localparam int unsigned c_AVG_LOG2_DEPTH = 3;

  typedef enum logic {
    s_FILL = 1'b0,
    s_RUN  = 1'b1
  } avg_state_t;

endpackage

// File: rtl/moving_average_filter_ring_buffer.sv
// Sample history ring: synchronous write, asynchronous read of the slot about to be overwritten.
module sample_ring_buffer
  import moving_average_filter_pkg::*;
#(
  parameter int unsigned g_Width      = 8,
  parameter int unsigned g_Log2_Depth = c_AVG_LOG2_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [g_Width-1:0] wr_data,
  output logic [g_Width-1:0] rd_data
);

  logic [g_Width-1:0]      mem [2**g_Log2_Depth];
  logic [g_Log2_Depth-1:0] wr_ptr;

  // Pointer width equals log2 depth, so the increment wraps with no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Storage carries no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[wr_ptr];

endmodule

// File: rtl/moving_average_filter.sv
// Boxcar moving-average filter over the last 2^g_Log2_Depth samples using a running sum.
module moving_average_filter
  import moving_average_filter_pkg::*;
#(
  parameter int unsigned g_Width      = 8,
  parameter int unsigned g_Log2_Depth = c_AVG_LOG2_DEPTH
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Clear,
  input  logic               i_Sample_DV,
  input  logic [g_Width-1:0] i_Sample,
  output logic               o_Average_DV,
  output logic [g_Width-1:0] o_Average,
  output logic               o_Primed
);

  localparam int unsigned c_SUM_W = g_Width + g_Log2_Depth;
  localparam int unsigned c_LAST  = (1 << g_Log2_Depth) - 1;
  localparam logic [g_Log2_Depth:0] c_LAST_CNT = c_LAST[g_Log2_Depth:0];

  avg_state_t             state, state_next;
  logic [c_SUM_W-1:0]     sum, next_sum;
  logic [g_Log2_Depth:0]  count;
  logic [g_Width-1:0]     rd_data, oldest;
  logic                   accept, window_full, strobe;

  assign accept      = i_Sample_DV && !i_Clear;
  assign window_full = (count == c_LAST_CNT);

  sample_ring_buffer #(
    .g_Width      (g_Width),
    .g_Log2_Depth (g_Log2_Depth)
  ) u_ring (
    .clk     (i_Clk),
    .rst_n   (i_Rst_L),
    .clear   (i_Clear),
    .wr_en   (accept),
    .wr_data (i_Sample),
    .rd_data (rd_data)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= s_FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (i_Clear) begin
      state_next = s_FILL;
    end else if (accept && state == s_FILL && window_full) begin
      state_next = s_RUN;
    end
  end

  // Oldest is zero while filling so stale ring contents never enter the sum.
  always_comb begin
    oldest   = (state == s_RUN) ? rd_data : '0;
    strobe   = accept && (state == s_RUN || window_full);
    next_sum = sum + c_SUM_W'(i_Sample) - c_SUM_W'(oldest);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sum          <= '0;
      count        <= '0;
      o_Average    <= '0;
      o_Average_DV <= 1'b0;
      o_Primed     <= 1'b0;
    end else if (i_Clear) begin
      sum          <= '0;
      count        <= '0;
      o_Average_DV <= 1'b0;
      o_Primed     <= 1'b0;
    end else begin
      o_Average_DV <= strobe;
      if (accept) begin
        sum <= next_sum;
        if (state == s_FILL) begin
          count <= count + 1'b1;
        end
      end
      if (strobe) begin
        o_Average <= next_sum[c_SUM_W-1:g_Log2_Depth];
        o_Primed  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_moving_average_filter.sv
// Scoreboard bench for moving_average_filter: a sample-window model queues expected averages per strobe.
module tb_moving_average_filter;

  localparam int unsigned L = 3;
  localparam int unsigned N = 8;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       dv;
  logic [7:0] sample;
  logic       avg_dv;
  logic [7:0] avg;
  logic       primed;

  int n_checks = 0;
  int n_fail   = 0;
  int win[$];
  int exp_q[$];
  int last_avg = 0;

  moving_average_filter #(
    .g_Width      (8),
    .g_Log2_Depth (L)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Clear      (clr),
    .i_Sample_DV  (dv),
    .i_Sample     (sample),
    .o_Average_DV (avg_dv),
    .o_Average    (avg),
    .o_Primed     (primed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst_n && avg_dv) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got avg=%0d with no strobe expected", avg);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (avg !== 8'(e)) begin
          n_fail++;
          $display("FAIL average: got %0d expected %0d", avg, e);
        end
      end
    end
  end

  task automatic drive_cycle(input logic v, input logic [7:0] s, input logic c);
    int acc;
    dv     = v;
    sample = s;
    clr    = c;
    if (c) begin
      win.delete();
    end else if (v) begin
      win.push_back(int'(s));
      if (win.size() > N) void'(win.pop_front());
      if (win.size() == N) begin
        acc = 0;
        foreach (win[i]) acc += win[i];
        last_avg = acc / N;
        exp_q.push_back(last_avg);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive_cycle(1'b0, 8'd0, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d strobes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; dv = 1'b0; sample = '0;
    #12;
    n_checks++;
    if ({avg_dv, primed, avg} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dv=%b primed=%b avg=%0d expected 0/0/0", avg_dv, primed, avg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      drive_cycle(1'b1, 8'd80, 1'b0);
      n_checks++;
      if (primed !== (i == 8)) begin
        n_fail++;
        $display("FAIL fill_primed: after strobe %0d got %b expected %b", i, primed, (i == 8));
      end
    end
    idle(2);
    wait_drain("fill");
  endtask

  task automatic test_sliding();
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 8'd0, 1'b0);
    idle(2);
    wait_drain("sliding");
  endtask

  task automatic test_full_scale();
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 8'd255, 1'b0);
    idle(2);
    wait_drain("full_scale");
    n_checks++;
    if (avg !== 8'd255) begin
      n_fail++;
      $display("FAIL full_scale_hold: got %0d expected 255", avg);
    end
  endtask

  task automatic test_clear();
    int held;
    held = last_avg;
    drive_cycle(1'b1, 8'd200, 1'b1);
    n_checks++;
    if (primed !== 1'b0 || avg_dv !== 1'b0 || avg !== 8'(held)) begin
      n_fail++;
      $display("FAIL clear_state: got primed=%b dv=%b avg=%0d expected 0/0/%0d", primed, avg_dv, avg, held);
    end
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 8'd40, 1'b0);
    idle(2);
    wait_drain("clear");
    n_checks++;
    if (avg !== 8'd40 || primed !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_refill: got avg=%0d primed=%b expected 40/1", avg, primed);
    end
  endtask

  task automatic test_truncation();
    drive_cycle(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 7; i++) drive_cycle(1'b1, 8'd1, 1'b0);
    drive_cycle(1'b1, 8'd2, 1'b0);
    idle(2);
    wait_drain("truncation");
    n_checks++;
    if (avg !== 8'd1) begin
      n_fail++;
      $display("FAIL truncation: got %0d expected 1", avg);
    end
  endtask

  task automatic test_midrun_reset();
    drive_cycle(1'b1, 8'd50, 1'b0);
    n_checks++;
    if (avg_dv !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_dv: got %b expected 1", avg_dv);
    end
    #2;
    rst_n = 1'b0;
    dv    = 1'b0;
    #1;
    n_checks++;
    if ({avg_dv, primed, avg} !== 10'd0) begin
      n_fail++;
      $display("FAIL async_reset: got dv=%b primed=%b avg=%0d expected 0/0/0", avg_dv, primed, avg);
    end
    exp_q.delete();
    win.delete();
    last_avg = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    n_checks++;
    if (primed !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_primed: got %b expected 0", primed);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_sliding();
    test_full_scale();
    test_clear();
    test_truncation();
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
